axis_split3: RTL and testbench

- Source-side companion to the three-input DSP stream block (dsp_axis).
- Takes one AXI-Stream carrying packed operand triples {c,b,a} and fans it out to three independent AXI-Stream master channels A, B and C, which connect to dsp_axis slave ports a/b/c.
- Each channel has its own registered output stage, so the channels can drain at different times while beat alignment and TLAST are preserved across all three.
- Also keeps beat and packet counters for debug.

---
 rtl/axis_split3.sv | 93 +++++++++
 tb/tb_axis_split3.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_split3.sv
// axis_split3: fans one AXI-Stream of packed {c,b,a} triples out to three
// independently drained AXI-Stream channels, with beat/packet debug counters.
module axis_split3 #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [3*DATA_WIDTH-1:0] s_axis_data,
    input  logic                    s_axis_valid,
    input  logic                    s_axis_last,
    output logic                    s_axis_ready,

    output logic [DATA_WIDTH-1:0]   m_axis_data_a,
    output logic                    m_axis_valid_a,
    output logic                    m_axis_last_a,
    input  logic                    m_axis_ready_a,

    output logic [DATA_WIDTH-1:0]   m_axis_data_b,
    output logic                    m_axis_valid_b,
    output logic                    m_axis_last_b,
    input  logic                    m_axis_ready_b,

    output logic [DATA_WIDTH-1:0]   m_axis_data_c,
    output logic                    m_axis_valid_c,
    output logic                    m_axis_last_c,
    input  logic                    m_axis_ready_c,

    output logic [CNT_WIDTH-1:0]    beat_count,
    output logic [CNT_WIDTH-1:0]    pkt_count
);

    logic [2:0]            valid_q;
    logic [2:0]            last_q;
    logic [2:0]            ready_in;
    logic [2:0]            free;
    logic [DATA_WIDTH-1:0] data_q [3];
    logic                  acc;

    assign ready_in = {m_axis_ready_c, m_axis_ready_b, m_axis_ready_a};

    // A slot can take a new beat if empty or emptying this cycle; the input
    // waits for all three so the channels never drift more than one beat.
    assign free         = ~valid_q | ready_in;
    assign s_axis_ready = &free;
    assign acc          = s_axis_valid & s_axis_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (acc) begin
                    valid_q[i] <= 1'b1;
                    last_q[i]  <= s_axis_last;
                    data_q[i]  <= s_axis_data[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (ready_in[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_count <= '0;
            pkt_count  <= '0;
        end else if (acc) begin
            beat_count <= beat_count + 1'b1;
            if (s_axis_last) begin
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end

    assign m_axis_data_a  = data_q[0];
    assign m_axis_valid_a = valid_q[0];
    assign m_axis_last_a  = last_q[0];

    assign m_axis_data_b  = data_q[1];
    assign m_axis_valid_b = valid_q[1];
    assign m_axis_last_b  = last_q[1];

    assign m_axis_data_c  = data_q[2];
    assign m_axis_valid_c = valid_q[2];
    assign m_axis_last_c  = last_q[2];

endmodule

// File: tb/tb_axis_split3.sv
// tb_axis_split3: randomized + directed scoreboard bench for axis_split3.
// Inputs change 1ns after posedge; the monitor samples on negedge.
module tb_axis_split3;

    localparam int DW = 16;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3*DW-1:0] s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_last = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   da, db, dc;
    logic            va, vb, vc;
    logic            la, lb, lc;
    logic            ra = 1'b1, rb = 1'b1, rc = 1'b1;
    logic [CW-1:0]   beat_count, pkt_count;

    int n_chk = 0;
    int n_fail = 0;
    bit acc_seen = 0;

    // reference state: one expected-beat queue per channel plus counts
    logic [DW:0] sb [3][$];
    int          exp_beats = 0;
    int          exp_pkts = 0;
    bit          hold_v [3];
    logic [DW:0] hold_d [3];

    always #5 clk = ~clk;

    axis_split3 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .s_axis_data(s_data), .s_axis_valid(s_valid),
        .s_axis_last(s_last), .s_axis_ready(s_ready),
        .m_axis_data_a(da), .m_axis_valid_a(va),
        .m_axis_last_a(la), .m_axis_ready_a(ra),
        .m_axis_data_b(db), .m_axis_valid_b(vb),
        .m_axis_last_b(lb), .m_axis_ready_b(rb),
        .m_axis_data_c(dc), .m_axis_valid_c(vc),
        .m_axis_last_c(lc), .m_axis_ready_c(rc),
        .beat_count(beat_count), .pkt_count(pkt_count)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [2:0]  mv, mr;
        logic [DW:0] md [3];
        bit          exp_rdy;
        mv = {vc, vb, va};
        mr = {rc, rb, ra};
        md[0] = {la, da};
        md[1] = {lb, db};
        md[2] = {lc, dc};
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                sb[i].delete();
                hold_v[i] = 0;
            end
            exp_beats = 0;
            exp_pkts = 0;
        end else begin
            exp_rdy = 1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("valid_%0d", i), 64'(mv[i]),
                    64'(sb[i].size() > 0));
                if (sb[i].size() > 0 && !mr[i]) exp_rdy = 0;
                if (hold_v[i])
                    chk($sformatf("hold_%0d", i), 64'(md[i]), 64'(hold_d[i]));
            end
            chk("s_ready", 64'(s_ready), 64'(exp_rdy));
            chk("beat_count", 64'(beat_count), 64'(exp_beats % (1 << CW)));
            chk("pkt_count", 64'(pkt_count), 64'(exp_pkts % (1 << CW)));
            for (int i = 0; i < 3; i++) begin
                hold_v[i] = mv[i] && !mr[i];
                hold_d[i] = md[i];
                if (mv[i] && mr[i] && sb[i].size() > 0)
                    chk($sformatf("data_%0d", i), 64'(md[i]),
                        64'(sb[i].pop_front()));
            end
            if (s_valid && s_ready) begin
                acc_seen = 1;
                for (int i = 0; i < 3; i++)
                    sb[i].push_back({s_last, s_data[i*DW +: DW]});
                exp_beats++;
                if (s_last) exp_pkts++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3*DW-1:0] d, input logic l);
        int n;
        s_data = d;
        s_last = l;
        s_valid = 1'b1;
        acc_seen = 0;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc_seen && n < 50);
        if (!acc_seen) chk("send_timeout", 64'(0), 64'(1));
        s_valid = 1'b0;
        acc_seen = 0;
    endtask

    task automatic do_reset(input int cycles);
        s_valid = 1'b0;
        reset = 1'b1;
        repeat (cycles) step();
        reset = 1'b0;
        chk("rst_valids", 64'({va, vb, vc}), 64'(0));
        chk("rst_lasts", 64'({la, lb, lc}), 64'(0));
        chk("rst_data", 64'({da, db, dc}), 64'(0));
        chk("rst_counts", 64'({beat_count, pkt_count}), 64'(0));
        chk("rst_ready", 64'(s_ready), 64'(1));
    endtask

    initial begin
        logic [3*DW-1:0] base;
        int n;
        base = {16'h0003, 16'h0002, 16'h0001};
        #1;
        do_reset(2);

        // back-to-back streaming, one packet of 10
        for (int i = 0; i < 10; i++) begin
            s_data = base + 48'(i) + (48'(i) << 16) + (48'(i) << 32);
            s_last = (i == 9);
            s_valid = 1'b1;
            step();
        end
        s_valid = 1'b0;
        step();
        chk("stream_beats", 64'(beat_count), 64'(10));
        chk("stream_pkts", 64'(pkt_count), 64'(1));

        // B lags for three cycles while A and C drain
        rb = 1'b0;
        send(48'h0c0c_0b0b_0a0a, 1'b0);
        fork
            send(48'h1c1c_1b1b_1a1a, 1'b1);
            begin
                repeat (3) step();
                rb = 1'b1;
            end
        join
        repeat (2) step();

        // full stall with a second beat waiting
        {ra, rb, rc} = 3'b000;
        send(48'h2c2c_2b2b_2a2a, 1'b0);
        s_data = 48'h3c3c_3b3b_3a3a;
        s_last = 1'b1;
        s_valid = 1'b1;
        acc_seen = 0;
        repeat (5) step();
        chk("stall_noacc", 64'(acc_seen), 64'(0));
        {ra, rb, rc} = 3'b111;
        n = 0;
        while (!acc_seen && n < 20) begin
            step();
            n++;
        end
        chk("stall_release", 64'(acc_seen), 64'(1));
        s_valid = 1'b0;
        acc_seen = 0;
        step();

        // reset while B still holds a beat
        rb = 1'b0;
        send(48'h4c4c_4b4b_4a4a, 1'b0);
        step();
        chk("pre_rst_vb", 64'(vb), 64'(1));
        do_reset(1);
        rb = 1'b1;
        send(48'h5c5c_5b5b_5a5a, 1'b1);
        step();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            ra = ($urandom_range(0, 3) != 0);
            rb = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 3) != 0);
            if (!s_valid || acc_seen) begin
                acc_seen = 0;
                s_valid = ($urandom_range(0, 2) != 0);
                s_data = {$urandom(), $urandom()};
                s_last = ($urandom_range(0, 3) == 0);
            end
            step();
        end
        s_valid = 1'b0;
        {ra, rb, rc} = 3'b111;
        repeat (3) step();
        chk("drained", 64'(sb[0].size() + sb[1].size() + sb[2].size()),
            64'(0));

        // counter wrap at 4 bits
        do_reset(2);
        for (int i = 0; i < 17; i++) begin
            s_data = {$urandom(), $urandom()};
            s_last = 1'b1;
            s_valid = 1'b1;
            step();
        end
        s_valid = 1'b0;
        step();
        chk("wrap_beats", 64'(beat_count), 64'(1));
        chk("wrap_pkts", 64'(pkt_count), 64'(1));
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
